sr04_echo_responder: RTL and testbench

- Emulates the HC-SR04 ultrasonic sensor, i.e. the responder end of the trig/echo protocol driven by the team's SR04 distance controller.
- Detects a valid trig pulse, waits the sensor burst delay, then drives echo high for distance_cm × US_PER_CM microseconds.
- Used in hardware-in-loop tests and simulation benches, so the Multi_Sensing_Watch distance path can be exercised without a physical sensor.

---
 rtl/sr04_echo_responder.sv | 188 ++++++++++++++++++
 tb/tb_sr04_echo_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr04_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sr04_echo_responder
//  Description : HC-SR04 ultrasonic sensor emulator. Accepts a trig pulse,
//                waits the burst delay, then answers with an echo pulse whose
//                width encodes the emulated target distance.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr04_echo_responder #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int TRIG_MIN_US = 10,
   parameter int BURST_US    = 200,
   parameter int US_PER_CM   = 58,
   parameter int MAX_CM      = 400,
   parameter int TIMEOUT_US  = 38000,
   parameter int HOLDOFF_US  = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   input  logic [9:0] distance_cm,
   output logic       echo,
   output logic       busy,
   output logic       trig_err,
   output logic [7:0] meas_cnt
);

   localparam int TICKS = (CLK_FREQ / 1_000_000 > 0) ? CLK_FREQ / 1_000_000 : 1;
   localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;

   localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS - 1);
   localparam logic [15:0]   TRIG_MIN_W  = 16'(TRIG_MIN_US);
   localparam logic [15:0]   BURST_W     = 16'(BURST_US);
   localparam logic [15:0]   US_PER_CM_W = 16'(US_PER_CM);
   localparam logic [15:0]   TIMEOUT_W   = 16'(TIMEOUT_US);
   localparam logic [15:0]   HOLDOFF_W   = 16'(HOLDOFF_US);
   localparam logic [9:0]    MAX_CM_W    = 10'(MAX_CM);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TRIG_HI = 3'd1,
      BURST   = 3'd2,
      ECHO    = 3'd3,
      HOLDOFF = 3'd4
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            trig_s1;
   logic            trig_s2;
   logic            trig_s3;
   logic            trig_rise;
   logic            trig_fall;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [15:0]     us_cnt;
   logic [15:0]     us_next;
   logic            state_entry;
   logic [9:0]      dist_lat;
   logic [15:0]     echo_width;
   logic            latch_dist;
   logic            trig_rej;
   logic            echo_end;

   assign trig_rise   = trig_s2 & ~trig_s3;
   assign trig_fall   = ~trig_s2 & trig_s3;
   assign tick        = (tick_cnt == TICK_LAST);
   assign state_entry = (state_next != state);
   // Saturating count including the tick of the current cycle, so each
   // interval ends exactly when its last microsecond completes.
   assign us_next     = (tick && us_cnt != 16'hFFFF) ? us_cnt + 16'd1 : us_cnt;

   // Two-stage synchronizer plus an edge-detect flop for the async trig input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trig_s1 <= 1'b0;
         trig_s2 <= 1'b0;
         trig_s3 <= 1'b0;
      end else begin
         trig_s1 <= trig;
         trig_s2 <= trig_s1;
         trig_s3 <= trig_s2;
      end
   end

   // Microsecond prescaler; restarts on every state entry for exact intervals
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (state_entry || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Microsecond counter for the current state, cleared on state entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         us_cnt <= '0;
      end else if (state_entry) begin
         us_cnt <= '0;
      end else begin
         us_cnt <= us_next;
      end
   end

   // Distance is captured once per accepted trig and held for the measurement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dist_lat <= '0;
      end else if (latch_dist) begin
         dist_lat <= distance_cm;
      end
   end

   // Echo width from the latched distance; zero or out-of-range gives timeout
   always_comb begin
      echo_width = 16'(dist_lat) * US_PER_CM_W;
      if (dist_lat == 10'd0 || dist_lat > MAX_CM_W) begin
         echo_width = TIMEOUT_W;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and per-transition strobes
   always_comb begin
      state_next = state;
      latch_dist = 1'b0;
      trig_rej   = 1'b0;
      echo_end   = 1'b0;
      case (state)
         IDLE: begin
            if (trig_rise) state_next = TRIG_HI;
         end
         TRIG_HI: begin
            if (trig_fall) begin
               if (us_next >= TRIG_MIN_W) begin
                  latch_dist = 1'b1;
                  state_next = BURST;
               end else begin
                  trig_rej   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         BURST: begin
            if (us_next >= BURST_W) state_next = ECHO;
         end
         ECHO: begin
            if (us_next >= echo_width) begin
               echo_end   = 1'b1;
               state_next = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (us_next >= HOLDOFF_W) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Registered outputs derived from the upcoming state and transition strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         echo     <= 1'b0;
         busy     <= 1'b0;
         trig_err <= 1'b0;
         meas_cnt <= '0;
      end else begin
         echo     <= (state_next == ECHO);
         busy     <= (state_next == BURST) || (state_next == ECHO) ||
                     (state_next == HOLDOFF);
         trig_err <= trig_rej;
         if (echo_end) meas_cnt <= meas_cnt + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sr04_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr04_echo_responder
//  Description : Directed self-checking bench for sr04_echo_responder, run
//                with a 2 MHz tick rate and shortened intervals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr04_echo_responder;

   localparam int CLK_FREQ    = 2_000_000;
   localparam int CPU         = 2;        // clock cycles per microsecond
   localparam int TRIG_MIN_US = 10;
   localparam int BURST_US    = 20;
   localparam int US_PER_CM   = 3;
   localparam int MAX_CM      = 400;
   localparam int TIMEOUT_US  = 1500;
   localparam int HOLDOFF_US  = 50;
   localparam int LAT_EXP     = BURST_US * CPU + 3;   // 2 sync + 1 detect cycle
   localparam int HOLD_EXP    = HOLDOFF_US * CPU;
   localparam int BOUND       = 20000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       trig = 1'b0;
   logic [9:0] distance_cm = '0;
   logic       echo;
   logic       busy;
   logic       trig_err;
   logic [7:0] meas_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int err_cnt = 0;

   sr04_echo_responder #(
      .CLK_FREQ   (CLK_FREQ),
      .TRIG_MIN_US(TRIG_MIN_US),
      .BURST_US   (BURST_US),
      .US_PER_CM  (US_PER_CM),
      .MAX_CM     (MAX_CM),
      .TIMEOUT_US (TIMEOUT_US),
      .HOLDOFF_US (HOLDOFF_US)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .trig       (trig),
      .distance_cm(distance_cm),
      .echo       (echo),
      .busy       (busy),
      .trig_err   (trig_err),
      .meas_cnt   (meas_cnt)
   );

   always #5 clk = ~clk;

   // Running count of trig_err pulses seen
   always @(negedge clk) begin
      if (trig_err === 1'b1) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
      n_cmp++;
      assert (obs >= exp - tol && obs <= exp + tol) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int us);
      trig = 1'b1;
      step(us * CPU);
      trig = 1'b0;
   endtask

   // Trig pulse, then cycles to echo rise, echo high cycles, echo-fall to busy-fall cycles
   task automatic meas(input int us, output int lat, output int hi, output int hold);
      pulse(us);
      lat = 0;
      while (echo !== 1'b1 && lat < BOUND) begin step(1); lat++; end
      hi = 0;
      while (echo === 1'b1 && hi < BOUND) begin hi++; step(1); end
      hold = 0;
      while (busy === 1'b1 && hold < BOUND) begin step(1); hold++; end
   endtask

   initial begin
      int lat, hi, hold, e0;
      bit seen_echo, seen_busy;

      // Reset
      distance_cm = 10'd100;
      step(5);
      chk("rst_echo", echo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_meas", meas_cnt, 0);
      chk("rst_err", trig_err, 0);
      rst = 1'b1;
      step(3);
      chk("post_rst_busy", busy, 0);

      // Nominal: 100 cm -> 300 us echo
      meas(12, lat, hi, hold);
      chk_tol("nom_latency", lat, LAT_EXP, 2);
      chk_tol("nom_width", hi, 300 * CPU, 1);
      chk("nom_meas", meas_cnt, 1);
      chk_tol("nom_holdoff", hold, HOLD_EXP, 1);

      // Short trig pulses: 5 us and 9 us both rejected
      e0 = err_cnt;
      seen_echo = 0;
      seen_busy = 0;
      pulse(5);
      for (int k = 0; k < 12; k++) begin
         step(1);
         if (echo === 1'b1) seen_echo = 1;
         if (busy === 1'b1) seen_busy = 1;
      end
      chk("short5_err", err_cnt - e0, 1);
      chk("short5_echo", seen_echo, 0);
      chk("short5_busy", seen_busy, 0);
      chk("short5_meas", meas_cnt, 1);
      e0 = err_cnt;
      pulse(9);
      step(12);
      chk("short9_err", err_cnt - e0, 1);
      chk("short9_busy", busy, 0);

      // Exactly the minimum width is accepted; 400 cm is the largest normal answer
      e0 = err_cnt;
      distance_cm = 10'd400;
      meas(10, lat, hi, hold);
      chk_tol("d400_width", hi, 1200 * CPU, 1);
      chk("d400_meas", meas_cnt, 2);
      chk("min_trig_err", err_cnt - e0, 0);

      // Zero and out-of-range distances give timeout width
      distance_cm = 10'd0;
      meas(12, lat, hi, hold);
      chk_tol("d0_width", hi, TIMEOUT_US * CPU, 1);
      chk("d0_meas", meas_cnt, 3);
      distance_cm = 10'd401;
      meas(12, lat, hi, hold);
      chk_tol("d401_width", hi, TIMEOUT_US * CPU, 1);
      chk("d401_meas", meas_cnt, 4);

      // Trig and distance changes while busy
      distance_cm = 10'd50;
      e0 = err_cnt;
      pulse(12);
      lat = 0;
      while (echo !== 1'b1 && lat < BOUND) begin step(1); lat++; end
      chk_tol("busy_latency", lat, LAT_EXP, 2);
      hi = 0;
      while (echo === 1'b1 && hi < BOUND) begin
         if (hi == 20) trig = 1'b1;
         if (hi == 30) distance_cm = 10'd7;
         if (hi == 44) trig = 1'b0;
         hi++;
         step(1);
      end
      chk_tol("busy_width", hi, 50 * US_PER_CM * CPU, 1);
      step(20);
      pulse(12);
      hold = 44;
      seen_echo = 0;
      while (busy === 1'b1 && hold < BOUND) begin
         if (echo === 1'b1) seen_echo = 1;
         step(1);
         hold++;
      end
      chk_tol("busy_holdoff", hold, HOLD_EXP, 1);
      chk("busy_no_echo", seen_echo, 0);
      chk("busy_no_err", err_cnt - e0, 0);
      chk("busy_meas", meas_cnt, 5);
      meas(12, lat, hi, hold);
      chk_tol("new_dist_width", hi, 7 * US_PER_CM * CPU, 1);
      chk("new_dist_meas", meas_cnt, 6);

      // Asynchronous reset in the middle of an echo
      distance_cm = 10'd100;
      pulse(12);
      lat = 0;
      while (echo !== 1'b1 && lat < BOUND) begin step(1); lat++; end
      step(10);
      #2 rst = 1'b0;
      #1;
      chk("arst_echo", echo, 0);
      chk("arst_busy", busy, 0);
      chk("arst_meas", meas_cnt, 0);
      step(3);
      rst = 1'b1;
      step(2);
      distance_cm = 10'd1;
      meas(12, lat, hi, hold);
      chk_tol("arst_after_width", hi, US_PER_CM * CPU, 1);
      chk("arst_after_meas", meas_cnt, 1);

      // Measurement counter wrap
      for (int i = 0; i < 254; i++) begin
         meas(12, lat, hi, hold);
         if (lat >= BOUND) break;
      end
      chk("wrap_255", meas_cnt, 255);
      meas(12, lat, hi, hold);
      chk("wrap_0", meas_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
